bitmanip_issue: RTL and testbench
=================================

# bitmanip_issue

Registered issue stage that sits directly upstream of the combinational bit-manipulation unit. It accepts decoded-register instruction packets over a valid/ready handshake and decodes the 32-bit RISC-V Zbkb-class instruction into the unit's 5-bit operation code. It selects register or immediate for the second operand and presents a stable, registered operand/op bundle. A 2-entry skid buffer keeps `in_ready` registered and sustains full throughput under downstream backpressure.

## Interface
- `XLEN`, 32, datapath width; legal values are 32 or 64 only.
- `OP_WIDTH`, 5, width of the operation code driven to the bitmanip unit.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `flush`  input  1  synchronous clear of all buffered entries.
- `in_valid`  input  1  input packet valid.
- `in_ready`  output  1  stage can accept a packet.
- `in_instr`  input  32  raw instruction word.
- `in_rs1`  input  XLEN  rs1 register value.
- `in_rs2`  input  XLEN  rs2 register value.
- `out_valid`  output  1  output bundle valid.
- `out_ready`  input  1  downstream accepts the bundle.
- `rs1_out`  output  XLEN  operand 1 to the bitmanip unit.
- `rs2_out`  output  XLEN  operand 2: rs2 value, or zero-extended shamt for immediate rotates.
- `op_out`  output  OP_WIDTH  operation code; 0 means no-op/illegal.
- `illegal_out`  output  1  instruction not supported for this XLEN.

## Operation
- Decode on input (opcode OP=0110011, OP-32=0111011, OP-IMM=0010011, OP-IMM-32=0011011):
  - 1 rol: f7 0110000, f3 001, OP.
  - 2 rolw: f7 0110000, f3 001, OP-32.
  - 3 ror: f7 0110000, f3 101, OP.
  - 4 rori: inst[31:26] 011000, f3 101, OP-IMM.
  - 5 roriw: f7 0110000, f3 101, OP-IMM-32.
  - 6 rorw: f7 0110000, f3 101, OP-32.
  - 7 andn: f7 0100000, f3 111, OP.
  - 8 orn: f7 0100000, f3 110, OP.
  - 9 xnor: f7 0100000, f3 100, OP.
  - 10 pack: f7 0000100, f3 100, OP.
  - 11 packh: f7 0000100, f3 111, OP.
  - 12 packw: f7 0000100, f3 100, OP-32.
  - 13 brev8: inst[31:20] 0x687, f3 101, OP-IMM.
  - 14 rev8: inst[31:20] 0x698 (XLEN 32) or 0x6B8 (XLEN 64), f3 101, OP-IMM.
  - 15 zip: inst[31:20] 0x08F, f3 001, OP-IMM.
  - 16 unzip: inst[31:20] 0x08F, f3 101, OP-IMM.
- XLEN legality:
  - W forms (2, 5, 6, 12) are legal only when XLEN=64.
  - zip/unzip are legal only when XLEN=32.
  - rori with inst[25]=1 is illegal at XLEN=32.
- Any unmatched or illegal word: `op_out`=0, `illegal_out`=1, operands still passed through. The packet is consumed normally, never dropped.
- `rs2_out`:
  - rori: zero-extended inst[25:20].
  - roriw: zero-extended inst[24:20].
  - All other ops: `in_rs2`.
- Buffering: a main register drives the outputs; a skid register catches a packet accepted while the main register is stalled.
  - `in_ready` = !skid_valid, registered.
  - Accept when `in_valid && in_ready`; output transfer when `out_valid && out_ready`.
  - On output transfer with skid full, skid moves to main the same edge.
  - Ordering is strictly FIFO.

## Timing
- Latency: 1 cycle from accept to `out_valid` when empty. Throughput: 1 packet/cycle with `out_ready` held high.
- Reset:
  - `out_valid`=0, `illegal_out`=0, `op_out`=0, `rs1_out`=0, `rs2_out`=0.
  - Skid empty; `in_ready`=0 while `rst` is high and 1 the cycle after.
- `flush` (when `rst` is low): both entries invalidated at the edge and `out_valid`=0 next cycle. An `in_valid` packet presented on the flush cycle is discarded.
- `rst` takes priority over `flush`. Reset mid-stall discards all held packets.
- Stall: while `out_valid && !out_ready`, all outputs hold stable. A second accepted packet fills skid, and `in_ready` drops the next cycle.
- Simultaneous accept and output transfer with skid empty: the new packet enters main, and `in_ready` stays 1.
- Both entries full and `out_ready`=1: main←skid, skid empties, and `in_ready` rises the next cycle.

## Test plan
- XLEN=32, in_instr=0x602091B3 (rol), rs1=0x80000001, rs2=4 -> next cycle out_valid=1, op_out=1, rs1_out=0x80000001, rs2_out=4, illegal_out=0.
- XLEN=32, in_instr=0x6050D193 (rori x3,x1,5), rs2=0xFFFFFFFF -> op_out=4, rs2_out=5.
- XLEN=32, in_instr=0x0820C1BB (packw) -> op_out=0, illegal_out=1. XLEN=64, same word -> op_out=12, illegal_out=0.
- XLEN=32, in_instr=0x6980D193 (rev8) -> op_out=14. XLEN=64, same word -> illegal_out=1.
- Backpressure: out_ready=0 with 3 back-to-back packets -> first two held, in_ready=0 after the second. Release out_ready -> packets exit in order on consecutive cycles and the third is accepted.
- Skid full, assert flush (then rst separately) -> out_valid=0 next cycle, no held packet ever emitted, all outputs 0 after rst.

Source files
------------

// File: rtl/bitmanip_issue.sv
`default_nettype none
// ============================================================================
// Module   : bitmanip_issue
// Purpose  : Registered issue stage with a 2-entry skid buffer that decodes
//            Zbkb-class instructions into the bitmanip unit's op code.
// Revision : 1.0 - initial release
// ============================================================================
module bitmanip_issue #(
  parameter int XLEN     = 32,
  parameter int OP_WIDTH = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [XLEN-1:0]     in_rs1,
  input  logic [XLEN-1:0]     in_rs2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     rs1_out,
  output logic [XLEN-1:0]     rs2_out,
  output logic [OP_WIDTH-1:0] op_out,
  output logic                illegal_out
);

  localparam int c_PW   = 1 + OP_WIDTH + 2 * XLEN;
  localparam bit c_IS64 = (XLEN == 64);

  localparam logic [6:0] c_OPC_OP       = 7'b0110011;
  localparam logic [6:0] c_OPC_OP32     = 7'b0111011;
  localparam logic [6:0] c_OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] c_OPC_OPIMM32  = 7'b0011011;
  localparam logic [6:0] c_F7_ROT       = 7'b0110000;
  localparam logic [6:0] c_F7_NEG       = 7'b0100000;
  localparam logic [6:0] c_F7_PACK      = 7'b0000100;
  localparam logic [11:0] c_IMM_BREV8   = 12'h687;
  localparam logic [11:0] c_IMM_REV8    = c_IS64 ? 12'h6B8 : 12'h698;
  localparam logic [11:0] c_IMM_ZIP     = 12'h08F;

  localparam logic [OP_WIDTH-1:0] c_OP_ROL   = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] c_OP_ROLW  = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] c_OP_ROR   = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] c_OP_RORI  = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] c_OP_RORIW = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] c_OP_RORW  = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] c_OP_ANDN  = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] c_OP_ORN   = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] c_OP_XNOR  = OP_WIDTH'(9);
  localparam logic [OP_WIDTH-1:0] c_OP_PACK  = OP_WIDTH'(10);
  localparam logic [OP_WIDTH-1:0] c_OP_PACKH = OP_WIDTH'(11);
  localparam logic [OP_WIDTH-1:0] c_OP_PACKW = OP_WIDTH'(12);
  localparam logic [OP_WIDTH-1:0] c_OP_BREV8 = OP_WIDTH'(13);
  localparam logic [OP_WIDTH-1:0] c_OP_REV8  = OP_WIDTH'(14);
  localparam logic [OP_WIDTH-1:0] c_OP_ZIP   = OP_WIDTH'(15);
  localparam logic [OP_WIDTH-1:0] c_OP_UNZIP = OP_WIDTH'(16);

  logic [6:0]          w_opc;
  logic [2:0]          w_f3;
  logic [6:0]          w_f7;
  logic [11:0]         w_imm;
  logic [OP_WIDTH-1:0] w_op;
  logic [XLEN-1:0]     w_rs2;
  logic [c_PW-1:0]     w_in_pkt;
  logic                w_unused;

  assign w_opc    = in_instr[6:0];
  assign w_f3     = in_instr[14:12];
  assign w_f7     = in_instr[31:25];
  assign w_imm    = in_instr[31:20];
  assign w_unused = ^{in_instr[19:15], in_instr[11:7]};

  always_comb begin
    w_op  = '0;
    w_rs2 = in_rs2;
    case (w_opc)
      c_OPC_OP: begin
        if (w_f7 == c_F7_ROT) begin
          if (w_f3 == 3'b001)      w_op = c_OP_ROL;
          else if (w_f3 == 3'b101) w_op = c_OP_ROR;
        end else if (w_f7 == c_F7_NEG) begin
          if (w_f3 == 3'b111)      w_op = c_OP_ANDN;
          else if (w_f3 == 3'b110) w_op = c_OP_ORN;
          else if (w_f3 == 3'b100) w_op = c_OP_XNOR;
        end else if (w_f7 == c_F7_PACK) begin
          if (w_f3 == 3'b100)      w_op = c_OP_PACK;
          else if (w_f3 == 3'b111) w_op = c_OP_PACKH;
        end
      end
      c_OPC_OP32: begin
        if (c_IS64) begin
          if (w_f7 == c_F7_ROT && w_f3 == 3'b001)       w_op = c_OP_ROLW;
          else if (w_f7 == c_F7_ROT && w_f3 == 3'b101)  w_op = c_OP_RORW;
          else if (w_f7 == c_F7_PACK && w_f3 == 3'b100) w_op = c_OP_PACKW;
        end
      end
      c_OPC_OPIMM: begin
        if (w_f3 == 3'b101) begin
          // 6-bit shamt; bit 25 set is only meaningful on a 64-bit datapath
          if (in_instr[31:26] == 6'b011000 && (c_IS64 || !in_instr[25])) begin
            w_op  = c_OP_RORI;
            w_rs2 = {{(XLEN-6){1'b0}}, in_instr[25:20]};
          end else if (w_imm == c_IMM_BREV8) begin
            w_op = c_OP_BREV8;
          end else if (w_imm == c_IMM_REV8) begin
            w_op = c_OP_REV8;
          end else if (w_imm == c_IMM_ZIP && !c_IS64) begin
            w_op = c_OP_UNZIP;
          end
        end else if (w_f3 == 3'b001) begin
          if (w_imm == c_IMM_ZIP && !c_IS64) w_op = c_OP_ZIP;
        end
      end
      c_OPC_OPIMM32: begin
        if (c_IS64 && w_f7 == c_F7_ROT && w_f3 == 3'b101) begin
          w_op  = c_OP_RORIW;
          w_rs2 = {{(XLEN-5){1'b0}}, in_instr[24:20]};
        end
      end
      default: w_op = '0;
    endcase
  end

  assign w_in_pkt = {(w_op == '0), w_op, in_rs1, w_rs2};

  logic            r_main_v;
  logic            r_skid_v;
  logic            r_in_ready;
  logic [c_PW-1:0] r_main_pkt;
  logic [c_PW-1:0] r_skid_pkt;

  logic w_acc;
  logic w_main_free;
  logic w_ld_main_in;
  logic w_ld_main_skid;
  logic w_ld_skid;
  logic w_main_v_nxt;
  logic w_skid_v_nxt;

  assign in_ready = r_in_ready & ~rst;

  always_comb begin
    w_acc          = in_valid & in_ready;
    w_main_free    = ~r_main_v | out_ready;
    w_ld_main_skid = w_main_free & r_skid_v & ~flush;
    w_ld_main_in   = w_main_free & ~r_skid_v & w_acc & ~flush;
    w_ld_skid      = w_acc & ~w_ld_main_in & ~flush;
    w_main_v_nxt   = w_main_free ? (r_skid_v | w_acc) : 1'b1;
    w_skid_v_nxt   = w_ld_skid ? 1'b1 : (w_ld_main_skid ? 1'b0 : r_skid_v);
    if (flush) begin
      w_main_v_nxt = 1'b0;
      w_skid_v_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_in_ready <= 1'b1;
      r_main_pkt <= '0;
      r_skid_pkt <= '0;
    end else begin
      r_main_v   <= w_main_v_nxt;
      r_skid_v   <= w_skid_v_nxt;
      r_in_ready <= ~w_skid_v_nxt;
      if (w_ld_main_in)
        r_main_pkt <= w_in_pkt;
      else if (w_ld_main_skid)
        r_main_pkt <= r_skid_pkt;
      if (w_ld_skid)
        r_skid_pkt <= w_in_pkt;
    end
  end

  assign out_valid = r_main_v;
  assign {illegal_out, op_out, rs1_out, rs2_out} = r_main_pkt;

endmodule
`default_nettype wire

// File: tb/tb_bitmanip_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitmanip_issue
// Purpose  : Directed bench driving one XLEN=32 and one XLEN=64 issue stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bitmanip_issue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_rs1, in_rs2;

  logic        r32_ready, o32_valid, o32_ill;
  logic [31:0] o32_rs1, o32_rs2;
  logic [4:0]  o32_op;
  logic        r64_ready, o64_valid, o64_ill;
  logic [63:0] o64_rs1, o64_rs2;
  logic [4:0]  o64_op;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bitmanip_issue #(.XLEN(32), .OP_WIDTH(5)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r32_ready),
    .in_instr(in_instr), .in_rs1(in_rs1[31:0]), .in_rs2(in_rs2[31:0]),
    .out_valid(o32_valid), .out_ready(out_ready), .rs1_out(o32_rs1), .rs2_out(o32_rs2),
    .op_out(o32_op), .illegal_out(o32_ill)
  );

  bitmanip_issue #(.XLEN(64), .OP_WIDTH(5)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r64_ready),
    .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(o64_valid), .out_ready(out_ready), .rs1_out(o64_rs1), .rs2_out(o64_rs2),
    .op_out(o64_op), .illegal_out(o64_ill)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [63:0] rs1, input logic [63:0] rs2);
    in_valid = 1'b1;
    in_instr = instr;
    in_rs1   = rs1;
    in_rs2   = rs2;
  endtask

  task automatic send(input logic [31:0] instr, input logic [63:0] rs1, input logic [63:0] rs2);
    drive(instr, rs1, rs2);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_rs1 = '0; in_rs2 = '0;
    step(); step();
    chk("rst_in_ready", {63'd0, r32_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, o32_valid}, 64'd0);
    chk("rst_op", {59'd0, o32_op}, 64'd0);
    chk("rst_rs1", {32'd0, o32_rs1}, 64'd0);
    chk("rst_rs2", {32'd0, o32_rs2}, 64'd0);
    chk("rst_ill", {63'd0, o32_ill}, 64'd0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", {63'd0, r32_ready}, 64'd1);

    // rol
    send(32'h602091B3, 64'h80000001, 64'd4);
    chk("rol_valid", {63'd0, o32_valid}, 64'd1);
    chk("rol_op", {59'd0, o32_op}, 64'd1);
    chk("rol_rs1", {32'd0, o32_rs1}, 64'h80000001);
    chk("rol_rs2", {32'd0, o32_rs2}, 64'd4);
    chk("rol_ill", {63'd0, o32_ill}, 64'd0);
    chk("rol64_op", {59'd0, o64_op}, 64'd1);

    // rori x3,x1,5 back-to-back with previous packet
    send(32'h6050D193, 64'h11, 64'hFFFFFFFF);
    chk("rori_op", {59'd0, o32_op}, 64'd4);
    chk("rori_rs2", {32'd0, o32_rs2}, 64'd5);
    chk("rori64_rs2", o64_rs2, 64'd5);

    // rori with shamt bit 5 set
    send(32'h6250D193, 64'h22, 64'h1234);
    chk("rori37_32_ill", {63'd0, o32_ill}, 64'd1);
    chk("rori37_32_rs2", {32'd0, o32_rs2}, 64'h1234);
    chk("rori37_64_op", {59'd0, o64_op}, 64'd4);
    chk("rori37_64_rs2", o64_rs2, 64'd37);

    // packw
    send(32'h0820C1BB, 64'h33, 64'h5678);
    chk("packw32_op", {59'd0, o32_op}, 64'd0);
    chk("packw32_ill", {63'd0, o32_ill}, 64'd1);
    chk("packw32_rs2", {32'd0, o32_rs2}, 64'h5678);
    chk("packw32_valid", {63'd0, o32_valid}, 64'd1);
    chk("packw64_op", {59'd0, o64_op}, 64'd12);
    chk("packw64_ill", {63'd0, o64_ill}, 64'd0);

    // rev8 (XLEN=32 encoding)
    send(32'h6980D193, 64'h44, 64'h0);
    chk("rev8_32_op", {59'd0, o32_op}, 64'd14);
    chk("rev8_64_ill", {63'd0, o64_ill}, 64'd1);
    chk("rev8_64_op", {59'd0, o64_op}, 64'd0);

    // zip and andn
    send(32'h08F09193, 64'h55, 64'h0);
    chk("zip32_op", {59'd0, o32_op}, 64'd15);
    chk("zip64_ill", {63'd0, o64_ill}, 64'd1);
    send(32'h4020F1B3, 64'h66, 64'h77);
    chk("andn_op", {59'd0, o32_op}, 64'd7);
    step();
    chk("drain_valid", {63'd0, o32_valid}, 64'd0);

    // backpressure: A, B accepted; C blocked until skid drains
    out_ready = 1'b0;
    send(32'h602091B3, 64'hA, 64'd1);
    send(32'h4020F1B3, 64'hB, 64'd2);
    chk("bp_in_ready_low", {63'd0, r32_ready}, 64'd0);
    chk("bp_hold_A", {32'd0, o32_rs1}, 64'hA);
    drive(32'h4020C1B3, 64'hC, 64'd3);
    step();
    chk("bp_stall_A", {32'd0, o32_rs1}, 64'hA);
    chk("bp_stall_op", {59'd0, o32_op}, 64'd1);
    chk("bp_stall_ready", {63'd0, r32_ready}, 64'd0);
    out_ready = 1'b1;
    step();
    chk("bp_out_B", {32'd0, o32_rs1}, 64'hB);
    chk("bp_out_B_op", {59'd0, o32_op}, 64'd7);
    chk("bp_ready_back", {63'd0, r32_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp_out_C", {32'd0, o32_rs1}, 64'hC);
    chk("bp_out_C_op", {59'd0, o32_op}, 64'd9);
    chk("bp_out_C_64", o64_rs1, 64'hC);
    step();
    chk("bp_empty", {63'd0, o32_valid}, 64'd0);

    // flush with both entries full
    out_ready = 1'b0;
    send(32'h602091B3, 64'hD1, 64'd1);
    send(32'h602091B3, 64'hD2, 64'd2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b1;
    chk("flush_valid", {63'd0, o32_valid}, 64'd0);
    chk("flush_ready", {63'd0, r32_ready}, 64'd1);
    step();
    chk("flush_no_emit", {63'd0, o32_valid}, 64'd0);
    // packet presented on a flush cycle is discarded
    flush = 1'b1;
    send(32'h602091B3, 64'hD3, 64'd3);
    flush = 1'b0;
    chk("flush_discard", {63'd0, o32_valid}, 64'd0);
    step();
    chk("flush_discard2", {63'd0, o64_valid}, 64'd0);

    // reset mid-stall
    out_ready = 1'b0;
    send(32'h602091B3, 64'hE1, 64'd7);
    send(32'h602091B3, 64'hE2, 64'd8);
    rst = 1'b1;
    step();
    chk("rst2_valid", {63'd0, o32_valid}, 64'd0);
    chk("rst2_rs1", {32'd0, o32_rs1}, 64'd0);
    chk("rst2_rs2", {32'd0, o32_rs2}, 64'd0);
    chk("rst2_op", {59'd0, o32_op}, 64'd0);
    chk("rst2_ill", {63'd0, o32_ill}, 64'd0);
    chk("rst2_ready", {63'd0, r32_ready}, 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst2_no_emit", {63'd0, o32_valid}, 64'd0);
    chk("rst2_ready_up", {63'd0, r32_ready}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
